// File: rtl/fpu_norm_pkg.sv
// Shared types and constants for the FPU post-add normalize/round stage.
// Internal exponent carries two guard bits so overflow past 255 stays visible.
package fpu_norm_pkg;

   localparam int FRAC_W    = 23;
   localparam int EXP_W     = 8;
   localparam int GRS_WIDTH = 3;
   localparam int MAN_W     = FRAC_W + 4;
   localparam int EXPI_W    = EXP_W + 2;
   localparam int CNT_W     = 5;

   localparam int HIDDEN_IDX = FRAC_W + 3;

   localparam logic [EXPI_W-1:0] EXP_MAX  = EXPI_W'(2**EXP_W - 1);
   localparam logic [EXPI_W-1:0] EXP_ONE  = EXPI_W'(1);
   localparam logic [CNT_W-1:0]  NORM_MAX = CNT_W'(26);

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      HOLD
   } norm_state_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
      logic zero;
   } fp_flags_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and IEEE-754 single packing.
// Input mantissa is {hidden, frac, G, R, S}; exponent is the unencoded biased value.
module fp_round_rne
   import fpu_norm_pkg::*;
(
   input  logic [MAN_W-1:0]  man_i,
   input  logic [EXPI_W-1:0] exp_i,
   input  logic              sign_i,
   input  logic              cancel_i,
   output fp32_t             result_o,
   output fp_flags_t         flags_o
);

   logic              g, r, s, lsb, inc, inexact, hidden;
   logic [FRAC_W+1:0] sum;
   logic [FRAC_W-1:0] frac;
   logic [EXPI_W-1:0] exp_adj;
   logic [EXP_W-1:0]  exp_enc;

   always_comb begin
      {g, r, s} = man_i[GRS_WIDTH-1:0];
      lsb       = man_i[GRS_WIDTH];
      inc       = g & (r | s | lsb);
      inexact   = g | r | s;
      sum       = {1'b0, man_i[MAN_W-1:GRS_WIDTH]} + {{(FRAC_W+1){1'b0}}, inc};

      // A carry out of {hidden, frac} renormalizes by one; the dropped bit is always 0.
      if (sum[FRAC_W+1]) begin
         hidden  = 1'b1;
         frac    = sum[FRAC_W:1];
         exp_adj = exp_i + EXP_ONE;
      end else begin
         hidden  = sum[FRAC_W];
         frac    = sum[FRAC_W-1:0];
         exp_adj = exp_i;
      end
      exp_enc = hidden ? exp_adj[EXP_W-1:0] : '0;

      result_o = '0;
      flags_o  = '0;
      if (cancel_i) begin
         flags_o.zero = 1'b1;
      end else if (exp_adj >= EXP_MAX) begin
         result_o.sign     = sign_i;
         result_o.exp      = EXP_MAX[EXP_W-1:0];
         flags_o.overflow  = 1'b1;
         flags_o.inexact   = 1'b1;
      end else begin
         result_o.sign     = sign_i;
         result_o.exp      = exp_enc;
         result_o.frac     = frac;
         flags_o.inexact   = inexact;
         flags_o.underflow = inexact && (exp_enc == '0);
         flags_o.zero      = (exp_enc == '0) && (frac == '0);
      end
   end

endmodule

// File: rtl/fp_norm_round.sv
// Post-adder stage: iterative left normalization (one bit per cycle), RNE rounding,
// single-precision packing, valid/ready on both sides.
module fp_norm_round
   import fpu_norm_pkg::*;
#(
   parameter int MANTISSA_WIDTH = FRAC_W,
   parameter int EXP_WIDTH      = EXP_W
) (
   input  logic                                  clk,
   input  logic                                  arst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [MANTISSA_WIDTH+3:0]             in_man,
   input  logic                                  in_carry,
   input  logic [EXP_WIDTH-1:0]                  in_exp,
   input  logic                                  in_sign,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [MANTISSA_WIDTH+EXP_WIDTH:0]     out_result,
   output logic                                  out_overflow,
   output logic                                  out_underflow,
   output logic                                  out_inexact,
   output logic                                  out_zero
);

   norm_state_e       state_q, state_d;
   logic [MAN_W-1:0]  man_q, man_d;
   logic [EXPI_W-1:0] exp_q, exp_d;
   logic              sign_q, sign_d;
   logic              cancel_q, cancel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   fp32_t             result_q, result_d, rnd_result;
   fp_flags_t         flags_q, flags_d, rnd_flags;
   logic [EXPI_W-1:0] exp_in;

   assign exp_in = (in_exp == '0) ? EXP_ONE : {2'b00, in_exp};

   fp_round_rne u_round (
      .man_i    (man_q),
      .exp_i    (exp_q),
      .sign_i   (sign_q),
      .cancel_i (cancel_q),
      .result_o (rnd_result),
      .flags_o  (rnd_flags)
   );

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d  = state_q;
      man_d    = man_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      cancel_d = cancel_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = in_sign;
               cancel_d = 1'b0;
               cnt_d    = '0;
               exp_d    = exp_in;
               if (in_carry) begin
                  man_d   = {1'b1, in_man[MAN_W-1:2], in_man[1] | in_man[0]};
                  exp_d   = exp_in + EXP_ONE;
                  state_d = ROUND;
               end else if (in_man == '0) begin
                  man_d    = '0;
                  cancel_d = 1'b1;
                  state_d  = ROUND;
               end else begin
                  man_d   = in_man;
                  state_d = (in_man[HIDDEN_IDX] || exp_in == EXP_ONE) ? ROUND : NORM;
               end
            end
         end
         NORM: begin
            // Sticky never migrates upward; R is refilled with zero.
            if (!man_q[HIDDEN_IDX] && exp_q > EXP_ONE) begin
               man_d = {man_q[MAN_W-2:1], 1'b0, man_q[0]};
               exp_d = exp_q - EXP_ONE;
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (man_d[HIDDEN_IDX] || exp_d == EXP_ONE || cnt_d == NORM_MAX) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            result_d = rnd_result;
            flags_d  = rnd_flags;
            state_d  = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= IDLE;
         man_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         cancel_q <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         man_q    <= man_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         cancel_q <= cancel_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == HOLD);
   assign out_result    = result_q;
   assign out_overflow  = flags_q.overflow;
   assign out_underflow = flags_q.underflow;
   assign out_inexact   = flags_q.inexact;
   assign out_zero      = flags_q.zero;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed corner cases plus randomized
// words compared against an arithmetic reference model.
module tb_fp_norm_round;

   logic        clk = 1'b0;
   logic        arst;
   logic        in_valid;
   logic        in_ready;
   logic [26:0] in_man;
   logic        in_carry;
   logic [7:0]  in_exp;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_inexact, out_zero;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fp_norm_round dut (
      .clk           (clk),
      .arst          (arst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_man        (in_man),
      .in_carry      (in_carry),
      .in_exp        (in_exp),
      .in_sign       (in_sign),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_inexact   (out_inexact),
      .out_zero      (out_zero)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   // Reference: significand as an integer (hidden..R) plus a separate sticky flag.
   // Flags are packed {overflow, underflow, inexact, zero}.
   function automatic void model(input logic [26:0] man, input logic carry, input logic [7:0] exp,
                                 input logic sign, output logic [31:0] res, output logic [3:0] fl,
                                 output int shifts);
      longint sig, keep;
      bit     st, g, rest, up, cancel;
      int     e, enc;
      e      = (exp == 0) ? 1 : int'(exp);
      sig    = longint'(man >> 1) + (carry ? (longint'(1) << 26) : 0);
      st     = man[0];
      shifts = 0;
      cancel = 0;
      if (sig >= (longint'(1) << 26)) begin
         st  = st | ((sig & 1) != 0);
         sig = sig >> 1;
         e++;
      end else if (sig == 0 && !st) begin
         cancel = 1;
      end else begin
         while (sig < (longint'(1) << 25) && e > 1 && shifts < 26) begin
            sig = sig << 1;
            e--;
            shifts++;
         end
      end
      keep = sig >> 2;
      g    = ((sig >> 1) & 1) != 0;
      rest = ((sig & 1) != 0) || st;
      up   = g && (rest || ((keep & 1) != 0));
      keep = keep + (up ? 1 : 0);
      if (keep == (longint'(1) << 24)) begin
         keep = keep >> 1;
         e++;
      end
      if (cancel) begin
         res = 32'h0;
         fl  = 4'b0001;
      end else if (e >= 255) begin
         res = {sign, 8'hFF, 23'h0};
         fl  = 4'b1010;
      end else begin
         enc = (keep >= (longint'(1) << 23)) ? e : 0;
         res = {sign, 8'(enc), 23'(keep)};
         fl  = {1'b0, (g || rest) && enc == 0, g || rest,
                enc == 0 && (keep & longint'(32'h7FFFFF)) == 0};
      end
   endfunction

   task automatic transact(input logic [26:0] man, input logic carry, input logic [7:0] exp,
                           input logic sign, input int hold,
                           output logic [31:0] res, output logic [3:0] fl, output int lat);
      int t;
      bit stable;
      res = '0;
      fl  = '0;
      lat = -1;
      in_man   = man;
      in_carry = carry;
      in_exp   = exp;
      in_sign  = sign;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      t = 0;
      while (t < 60) begin
         @(negedge clk);
         t++;
         if (out_valid) break;
      end
      if (!out_valid) begin
         check("valid_timeout", 0, 1);
         return;
      end
      lat = t;
      res = out_result;
      fl  = {out_overflow, out_underflow, out_inexact, out_zero};
      if (hold > 0) begin
         stable = 1;
         repeat (hold) begin
            @(negedge clk);
            if (out_result !== res || !out_valid || in_ready) stable = 0;
         end
         check("hold_stable", stable, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("release", {out_valid, in_ready}, 2'b01);
   endtask

   task automatic directed(input string name, input logic [26:0] man, input logic carry,
                           input logic [7:0] exp, input logic sign, input logic [31:0] want_res,
                           input logic [3:0] want_fl, input int want_lat, input int hold);
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      transact(man, carry, exp, sign, hold, res, fl, lat);
      check({name, "_result"}, res, want_res);
      check({name, "_flags"}, fl, want_fl);
      check({name, "_latency"}, lat, want_lat);
   endtask

   initial begin
      logic [31:0] res, want_res;
      logic [3:0]  fl, want_fl;
      logic [26:0] m;
      logic [7:0]  e;
      int          lat, shifts, mode, pick;
      bit          spurious;

      arst      = 1'b1;
      in_valid  = 1'b0;
      in_man    = '0;
      in_carry  = 1'b0;
      in_exp    = '0;
      in_sign   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_result", out_result, 32'h0);
      check("reset_flags", {out_overflow, out_underflow, out_inexact, out_zero}, 4'b0000);
      arst = 1'b0;
      @(negedge clk);

      directed("two",        27'h0000000, 1, 8'd127, 0, 32'h40000000, 4'b0000, 2, 0);
      directed("carry_3p0",  27'h4000000, 1, 8'd127, 0, 32'h40400000, 4'b0000, 2, 0);
      directed("cancel",     27'h0000000, 0, 8'd127, 1, 32'h00000000, 4'b0001, 2, 0);
      directed("left_norm",  27'h0800000, 0, 8'd127, 0, 32'h3E000000, 4'b0000, 5, 0);
      directed("tie_odd",    27'h400000C, 0, 8'd127, 0, 32'h3F800002, 4'b0010, 2, 0);
      directed("tie_even",   27'h4000004, 0, 8'd127, 0, 32'h3F800000, 4'b0010, 2, 0);
      directed("tie_neg",    27'h400000C, 0, 8'd127, 1, 32'hBF800002, 4'b0010, 2, 0);
      directed("overflow",   27'h0000000, 1, 8'd254, 0, 32'h7F800000, 4'b1010, 2, 0);
      directed("round_carry",27'h7FFFFFC, 0, 8'd127, 0, 32'h40000000, 4'b0010, 2, 0);
      directed("round_ovf",  27'h7FFFFFC, 0, 8'd254, 1, 32'hFF800000, 4'b1010, 2, 0);
      directed("denorm",     27'h0000010, 0, 8'd1,   0, 32'h00000002, 4'b0000, 2, 0);
      directed("exp0_unf",   27'h0000014, 0, 8'd0,   0, 32'h00000002, 4'b0110, 2, 0);
      directed("denorm_up",  27'h3FFFFFC, 0, 8'd1,   0, 32'h00800000, 4'b0010, 2, 0);
      directed("backpress",  27'h4000000, 0, 8'd100, 0, 32'h32000000, 4'b0000, 2, 10);

      // Reset while normalizing must drop the word entirely.
      @(negedge clk);
      in_man   = 27'h0000100;
      in_carry = 1'b0;
      in_exp   = 8'd127;
      in_sign  = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("norm_busy", {out_valid, in_ready}, 2'b00);
      arst = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      @(negedge clk);
      arst = 1'b0;
      spurious = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) spurious = 1;
      end
      check("no_spurious", spurious, 0);

      for (int i = 0; i < 300; i++) begin
         mode = $urandom_range(0, 3);
         m    = 27'($urandom);
         case (mode)
            0: m[26] = 1'b1;
            1: m = m >> $urandom_range(1, 26);
            3: m = 27'($urandom_range(0, 15));
            default: ;
         endcase
         pick = $urandom_range(0, 9);
         if (pick == 0)      e = 8'($urandom_range(0, 3));
         else if (pick == 1) e = 8'($urandom_range(250, 254));
         else                e = 8'($urandom_range(1, 254));
         model(m, mode == 2, e, 1'($urandom), want_res, want_fl, shifts);
         transact(m, mode == 2, e, want_res[31], $urandom_range(0, 2), res, fl, lat);
         check("rand_result", res, want_res);
         check("rand_flags", fl, want_fl);
         check("rand_latency", lat, 2 + shifts);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
